// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall-bus types, stall patterns and divide FSM encodings
package pipe_ctrl_pkg;

   typedef logic [5:0] stall_bus_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_LU   = 6'b000111;
   localparam stall_bus_t STALL_DIV  = 6'b001111;
   localparam stall_bus_t STALL_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // Widest active request wins; each wider pattern is a superset of the narrower ones.
   function automatic stall_bus_t stall_merge(input logic mem_wait,
                                              input logic div_stall,
                                              input logic load_use);
      stall_bus_t s;
      if (mem_wait)       s = STALL_MEM;
      else if (div_stall) s = STALL_DIV;
      else if (load_use)  s = STALL_LU;
      else                s = STALL_NONE;
      s[5] = NO_STOP;
      return s;
   endfunction

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// rtl/pipe_ctrl_div_seq.sv - divider start/count/done sequencer (IDLE/BUSY/DONE + down-counter)
module pipe_ctrl_div_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic i_div_req,
   input  logic i_mem_wait,
   output logic o_div_start,
   output logic o_div_done,
   output logic o_stall_req,
   output logic o_busy
);

   div_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= DIV_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The counter never pauses for MEM waits; only DONE is held while EX cannot advance.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_div_start = 1'b0;
      o_div_done  = 1'b0;
      o_stall_req = 1'b0;
      case (r_state)
         DIV_IDLE: begin
            if (i_div_req) begin
               o_div_start = 1'b1;
               o_stall_req = 1'b1;
               w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
               w_state_nxt = DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            o_stall_req = 1'b1;
            if (r_cnt != '0) w_cnt_nxt   = r_cnt - CNT_W'(1);
            else             w_state_nxt = DIV_DONE;
         end
         DIV_DONE: begin
            o_div_done = 1'b1;
            if (!i_mem_wait) w_state_nxt = DIV_IDLE;
         end
         default: w_state_nxt = DIV_IDLE;
      endcase
   end

   assign o_busy = (r_state != DIV_IDLE);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall sequencer: merges ID/EX/MEM requests and drives the divider
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        div_req,
   input  logic        mem_req,
   input  logic        mem_ack,
   output stall_bus_t  stall,
   output logic        div_start,
   output logic        div_done,
   output logic        busy,
   output logic [31:0] stall_cycles
);

   logic        w_mem_wait;
   logic        w_div_stall;
   logic [31:0] r_stall_cycles;

   assign w_mem_wait = mem_req & ~mem_ack;

   pipe_ctrl_div_seq #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div_seq (
      .clk         (clk),
      .rst         (rst),
      .i_div_req   (div_req),
      .i_mem_wait  (w_mem_wait),
      .o_div_start (div_start),
      .o_div_done  (div_done),
      .o_stall_req (w_div_stall),
      .o_busy      (busy)
   );

   assign stall = stall_merge(w_mem_wait, w_div_stall, stallreq_id);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                r_stall_cycles <= '0;
      else if (stall[0] == STOP) r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   localparam int DIVC = 33;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stallreq_id = 1'b0;
   logic        div_req = 1'b0;
   logic        mem_req = 1'b0;
   logic        mem_ack = 1'b0;
   logic [5:0]  stall;
   logic        div_start;
   logic        div_done;
   logic        busy;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_errors = 0;

   pipe_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .div_req      (div_req),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .stall        (stall),
      .div_start    (div_start),
      .div_done     (div_done),
      .busy         (busy),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       sid;
      logic       dreq;
      logic       mreq;
      logic       mack;
      logic [5:0] exp_stall;
      logic       exp_start;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic sid, input logic dreq, input logic mreq, input logic mack);
      stallreq_id = sid;
      div_req     = dreq;
      mem_req     = mreq;
      mem_ack     = mack;
   endtask

   // Called #1 after a rising edge; drives, samples mid-cycle, then advances one cycle.
   task automatic cyc(input string tag, input logic sid, input logic dreq, input logic mreq,
                      input logic mack, input logic [5:0] e_stall, input logic e_start,
                      input logic e_done, input logic e_busy);
      drive(sid, dreq, mreq, mack);
      #3;
      chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
      chk({tag, ".div_start"}, 32'(div_start), 32'(e_start));
      chk({tag, ".div_done"}, 32'(div_done), 32'(e_done));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Reference model: a divide is described by its age in cycles since the start pulse.
   bit          m_active;
   int          m_age;
   logic [31:0] m_scount;

   initial begin
      logic [5:0] e_stall;
      logic       e_start, e_done, e_busy, e_pat, mw;
      int         done_seen;

      tbl[0] = '{0, 0, 0, 0, 6'b000000, 0};
      tbl[1] = '{1, 0, 0, 0, 6'b000111, 0};
      tbl[2] = '{0, 0, 1, 0, 6'b011111, 0};
      tbl[3] = '{0, 0, 1, 1, 6'b000000, 0};
      tbl[4] = '{1, 0, 1, 1, 6'b000111, 0};
      tbl[5] = '{0, 1, 0, 0, 6'b001111, 1};
      tbl[6] = '{1, 1, 1, 0, 6'b011111, 1};
      tbl[7] = '{1, 1, 0, 1, 6'b001111, 1};

      // Reset state
      rst = 1'b0;
      drive(0, 0, 0, 0);
      #2;
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.div_done", 32'(div_done), 32'd0);
      chk("reset.div_start", 32'(div_start), 32'd0);
      chk("reset.stall_cycles", stall_cycles, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      chk("release.stall", 32'(stall), 32'd0);
      chk("release.busy", 32'(busy), 32'd0);

      // Combinational merge in IDLE; inputs cleared before each rising edge
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(tbl[i].sid, tbl[i].dreq, tbl[i].mreq, tbl[i].mack);
         #1;
         chk($sformatf("tbl%0d.stall", i), 32'(stall), 32'(tbl[i].exp_stall));
         chk($sformatf("tbl%0d.div_start", i), 32'(div_start), 32'(tbl[i].exp_start));
         #1;
         drive(0, 0, 0, 0);
      end
      @(posedge clk);
      #1;
      chk("tbl.stall_cycles", stall_cycles, 32'd0);
      chk("tbl.busy", 32'(busy), 32'd0);

      // Single-cycle load-use
      do_reset();
      cyc("lu0", 1, 0, 0, 0, 6'b000111, 0, 0, 0);
      cyc("lu1", 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      chk("lu.stall_cycles", stall_cycles, 32'd1);

      // Plain divide
      do_reset();
      for (int k = 0; k <= DIVC + 1; k++)
         cyc($sformatf("div%0d", k), 0, 1, 0, 0,
             (k <= DIVC) ? 6'b001111 : 6'b000000, k == 0, k == DIVC + 1, k >= 1);
      cyc("div_end", 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      chk("div.stall_cycles", stall_cycles, 32'(DIVC + 1));

      // Divide overlapped by a MEM wait T+30..T+36
      do_reset();
      for (int k = 0; k <= DIVC + 5; k++) begin
         logic w;
         w = (k >= 30 && k <= 36);
         cyc($sformatf("dm%0d", k), 0, k <= DIVC + 4, w, 0,
             w ? 6'b011111 : (k <= DIVC) ? 6'b001111 : 6'b000000,
             k == 0, k >= DIVC + 1 && k <= DIVC + 4, k >= 1 && k <= DIVC + 4);
      end

      // Priority: divide over load-use, MEM over both
      do_reset();
      cyc("pri0", 1, 1, 0, 0, 6'b001111, 1, 0, 0);
      cyc("pri1", 1, 1, 1, 0, 6'b011111, 0, 0, 1);

      // Reset mid-divide when the counter reaches 10
      do_reset();
      for (int k = 0; k < DIVC - 10; k++)
         cyc($sformatf("rm%0d", k), 0, 1, 0, 0, 6'b001111, k == 0, 0, k >= 1);
      rst = 1'b0;
      #1;
      chk("rm.busy_async", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(0, 0, 0, 0);
      done_seen = 0;
      for (int k = 0; k < DIVC + 8; k++) begin
         @(posedge clk);
         #1;
         if (div_done) done_seen++;
      end
      chk("rm.no_done", 32'(done_seen), 32'd0);
      cyc("rm.restart", 0, 1, 0, 0, 6'b001111, 1, 0, 0);
      cyc("rm.restart1", 0, 1, 0, 0, 6'b001111, 0, 0, 1);

      // Randomised run against the reference model
      do_reset();
      m_active = 0;
      m_age    = 0;
      m_scount = '0;
      for (int n = 0; n < 4000; n++) begin
         drive($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
         mw = mem_req & ~mem_ack;
         if (!m_active) begin
            e_start = div_req; e_pat = div_req; e_done = 0; e_busy = 0;
         end else if (m_age <= DIVC) begin
            e_start = 0; e_pat = 1; e_done = 0; e_busy = 1;
         end else begin
            e_start = 0; e_pat = 0; e_done = 1; e_busy = 1;
         end
         e_stall = mw ? 6'b011111 : e_pat ? 6'b001111 : stallreq_id ? 6'b000111 : 6'b000000;
         #3;
         chk("rnd.stall", 32'(stall), 32'(e_stall));
         chk("rnd.div_start", 32'(div_start), 32'(e_start));
         chk("rnd.div_done", 32'(div_done), 32'(e_done));
         chk("rnd.busy", 32'(busy), 32'(e_busy));
         chk("rnd.stall_cycles", stall_cycles, m_scount);
         @(posedge clk);
         #1;
         if (!m_active) begin
            if (e_start) begin
               m_active = 1;
               m_age    = 1;
            end
         end else if (m_age <= DIVC) begin
            m_age++;
         end else if (!mw) begin
            m_active = 0;
         end
         if (e_stall[0]) m_scount = m_scount + 32'd1;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
